rc755_flash_seq: RTL and testbench
==================================

RC755_FLASH_SEQ -- requirements
Module: rc755_flash_seq

Interface
REQ-001 Parameter WE_CYC, 2, clocks FL_WEn is held low per command write cycle (legal 1..7).
REQ-002 Parameter RD_CYC, 2, clocks FL_OEn is held low per status read cycle (legal 1..7).
REQ-003 Parameter TO_POLLS, 24'hFFFFFF, maximum status reads before timeout.
REQ-004 SLT_CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-005 SLT_RESETn  in  1  reset; asynchronous, active-low.
REQ-006 req  in  1  operation request, sampled only in IDLE.
REQ-007 op  in  2  00 program byte, 01 sector erase, 10 chip erase, 11 reset/read-array.
REQ-008 addr  in  19  flash byte address; ROM_BA[5:0] concatenated with 13-bit page offset.
REQ-009 wdata  in  8  program data.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-clock completion pulse.
REQ-012 err  out  1  failure flag, valid with done.
REQ-013 FL_A  out  19  flash address.
REQ-014 FL_DO  out  8  flash write data.
REQ-015 FL_DOE  out  1  data bus drive enable.
REQ-016 FL_DI  in  8  flash read data.
REQ-017 FL_CEn, FL_WEn, FL_OEn  out  1 each  flash strobes, active-low.

Function
REQ-018 FSM states SHALL be IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, R_GAP, VERIFY, FINISH.
REQ-019 req=1 in IDLE at edge N SHALL latch op/addr/wdata and assert busy and W_SETUP from edge N+1; req at any other time SHALL be ignored.
REQ-020 Write cycle: W_SETUP 1 clk (CEn=0, WEn=1, DOE=1, FL_A/FL_DO valid), W_PULSE WE_CYC clks (WEn=0), W_HOLD 1 clk (WEn=1, CEn=1, FL_A/FL_DO unchanged).
REQ-021 Command tables (addr/data): op00 555/AA, 2AA/55, 555/A0, addr/wdata; op01 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, addr/30; op10 same as op01 with last 555/10; op11 000/F0.
REQ-022 After the last command write: op11 SHALL go to FINISH; other ops SHALL enter status polling.
REQ-023 Poll read: R_PULSE RD_CYC clks (CEn=0, OEn=0, DOE=0, FL_A=latched addr), FL_DI sampled on final R_PULSE edge, then R_GAP 1 clk with all strobes high.
REQ-024 Two consecutive reads with equal DQ6 SHALL end polling with success.
REQ-025 DQ6 toggled and DQ5=1 on a read SHALL force one further read; if DQ6 still toggles, err SHALL be set.
REQ-026 Poll count reaching TO_POLLS without success SHALL set err.
REQ-027 On err (REQ-025/026) the FSM SHALL issue one 000/F0 write cycle before FINISH.
REQ-028 FINISH: done=1 for exactly one clock, busy=0 on the following edge, return to IDLE; req there SHALL be ignored.
REQ-029 err SHALL hold until the next accepted req clears it.
REQ-030 FL_CEn and FL_OEn SHALL never be low with FL_DOE=1; FL_WEn and FL_OEn SHALL never be low simultaneously.
REQ-031 Poll counter SHALL be 24 bits and SHALL saturate.

Reset
REQ-032 SLT_RESETn low SHALL immediately force IDLE, busy=0, done=0, err=0, FL_CEn=FL_WEn=FL_OEn=1, FL_DOE=0, FL_A=0, FL_DO=0, even mid-pulse.
REQ-033 Reset released mid-operation SHALL NOT resume the aborted sequence; a new req is required.

Configuration
REQ-034 Macro RC755_FLASH_VERIFY_EN defined: after successful op00 polling, one extra read cycle at addr compared with wdata; mismatch SHALL set err (with F0 reset per REQ-027).
REQ-035 Macro undefined: no VERIFY state; op00 SHALL finish directly after polling.

Verification
REQ-036 Reset: SLT_RESETn low mid-W_PULSE -> FL_WEn=1, FL_CEn=1, busy=0 within the same clock, no done.
REQ-037 op00, addr 19'h0A123, wdata 8'h5A, WE_CYC=2 -> writes 555/AA, 2AA/55, 555/A0, 0A123/5A, each 4 clks (16 clks total); DQ6 steady on first two reads -> done, err=0.
REQ-038 op01, addr 19'h40000, flash model toggles DQ6 for 10 reads -> six command writes ending 40000/30, done after 11 reads, err=0.
REQ-039 op10, model toggles DQ6 with DQ5=1 -> one extra read, err=1, 000/F0 write seen, then done.
REQ-040 TO_POLLS=4, DQ6 always toggles -> 4 reads, F0 write, done with err=1; req held high while busy -> ignored, no second sequence.
REQ-041 RC755_FLASH_VERIFY_EN defined, op00 wdata 8'hA5, read-back 8'hA4 -> err=1 with done; identical run with macro undefined -> err=0.

Source files
------------

// File: rtl/rc755_flash_seq.sv
// rc755_flash_seq: command/poll sequencer for a parallel NOR flash (program, sector/chip erase, reset).
// Optional read-back verify after a byte program is enabled by defining RC755_FLASH_VERIFY_EN.
module rc755_flash_seq #(
   parameter int unsigned WE_CYC   = 2,
   parameter int unsigned RD_CYC   = 2,
   parameter logic [23:0] TO_POLLS = 24'hFFFFFF
) (
   input  logic        SLT_CLOCK,
   input  logic        SLT_RESETn,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic [18:0] addr,
   input  logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [18:0] FL_A,
   output logic [7:0]  FL_DO,
   output logic        FL_DOE,
   input  logic [7:0]  FL_DI,
   output logic        FL_CEn,
   output logic        FL_WEn,
   output logic        FL_OEn
);

   localparam logic [2:0]  WE_LAST  = 3'(WE_CYC - 1);
   localparam logic [2:0]  RD_LAST  = 3'(RD_CYC - 1);
   localparam logic [18:0] A_555    = 19'h00555;
   localparam logic [18:0] A_2AA    = 19'h002AA;
   localparam logic [23:0] POLL_MAX = 24'hFFFFFF;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_PULSE,
      R_GAP,
`ifdef RC755_FLASH_VERIFY_EN
      VERIFY,
`endif
      FINISH
   } state_t;

   state_t      state;
   state_t      state_n;
   state_t      succ_state;

   logic [1:0]  op_q;
   logic [18:0] addr_q;
   logic [7:0]  wdata_q;
   logic [2:0]  cyc;
   logic [2:0]  idx;
   logic [2:0]  last_idx;
   logic        abort_q;
   logic        err_q;
   logic [23:0] poll_cnt;
   logic [7:0]  dq_q;
   logic        prev_dq6;
   logic        have_prev;
   logic        retry_q;
   logic        toggled;

   logic        accept;
   logic        poll_start;
   logic        rd_sample;
   logic        retry_set;
   logic        fail;

   logic [18:0] cmd_addr;
   logic [7:0]  cmd_data;

`ifdef RC755_FLASH_VERIFY_EN
   logic        vfy_q;
   logic        vfy_sample;
`else
   logic        unused_dq;
   assign unused_dq = ^{dq_q[7], dq_q[4:0]};
`endif

   assign toggled = dq_q[6] ^ prev_dq6;

   // Abort recovery is always a single 000/F0 write; otherwise the length depends on the op.
   always_comb begin
      last_idx = 3'd0;
      if (!abort_q) begin
         case (op_q)
            2'b00:   last_idx = 3'd3;
            2'b01,
            2'b10:   last_idx = 3'd5;
            default: last_idx = 3'd0;
         endcase
      end
   end

   // Unlock/command tables indexed by the write-cycle counter.
   always_comb begin
      cmd_addr = 19'h00000;
      cmd_data = 8'hF0;
      if (!abort_q) begin
         case (op_q)
            2'b00: begin
               case (idx)
                  3'd0:    begin cmd_addr = A_555;  cmd_data = 8'hAA;   end
                  3'd1:    begin cmd_addr = A_2AA;  cmd_data = 8'h55;   end
                  3'd2:    begin cmd_addr = A_555;  cmd_data = 8'hA0;   end
                  default: begin cmd_addr = addr_q; cmd_data = wdata_q; end
               endcase
            end
            2'b01,
            2'b10: begin
               case (idx)
                  3'd0, 3'd3: begin cmd_addr = A_555; cmd_data = 8'hAA; end
                  3'd1, 3'd4: begin cmd_addr = A_2AA; cmd_data = 8'h55; end
                  3'd2:       begin cmd_addr = A_555; cmd_data = 8'h80; end
                  default: begin
                     if (op_q == 2'b01) begin
                        cmd_addr = addr_q;
                        cmd_data = 8'h30;
                     end else begin
                        cmd_addr = A_555;
                        cmd_data = 8'h10;
                     end
                  end
               endcase
            end
            default: begin
               cmd_addr = 19'h00000;
               cmd_data = 8'hF0;
            end
         endcase
      end
   end

   // Where a successful poll leads: straight to FINISH unless a program needs read-back.
   always_comb begin
      succ_state = FINISH;
`ifdef RC755_FLASH_VERIFY_EN
      if (op_q == 2'b00) succ_state = VERIFY;
`endif
   end

   always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
      if (!SLT_RESETn) state <= IDLE;
      else             state <= state_n;
   end

   // Next-state decode; R_GAP judges the read just captured in dq_q against the one before.
   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      poll_start = 1'b0;
      rd_sample  = 1'b0;
      retry_set  = 1'b0;
      fail       = 1'b0;
`ifdef RC755_FLASH_VERIFY_EN
      vfy_sample = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               state_n = W_SETUP;
            end
         end
         W_SETUP: state_n = W_PULSE;
         W_PULSE: begin
            if (cyc == WE_LAST) state_n = W_HOLD;
         end
         W_HOLD: begin
            if (idx != last_idx) begin
               state_n = W_SETUP;
            end else if (abort_q || op_q == 2'b11) begin
               state_n = FINISH;
            end else begin
               poll_start = 1'b1;
               state_n    = R_PULSE;
            end
         end
         R_PULSE: begin
            if (cyc == RD_LAST) begin
               rd_sample = 1'b1;
               state_n   = R_GAP;
            end
         end
         R_GAP: begin
            state_n = R_PULSE;
            if (have_prev && !toggled)
               state_n = succ_state;
            else if (retry_q)
               fail = 1'b1;
            else if (have_prev && dq_q[5])
               retry_set = 1'b1;
            else if (poll_cnt >= TO_POLLS)
               fail = 1'b1;
`ifdef RC755_FLASH_VERIFY_EN
            if (vfy_q) begin
               retry_set = 1'b0;
               fail      = (dq_q != wdata_q);
               state_n   = FINISH;
            end
`endif
            if (fail) state_n = W_SETUP;
         end
`ifdef RC755_FLASH_VERIFY_EN
         VERIFY: begin
            if (cyc == RD_LAST) begin
               vfy_sample = 1'b1;
               state_n    = R_GAP;
            end
         end
`endif
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: latched request, cycle/command counters and the polling history.
   always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
      if (!SLT_RESETn) begin
         op_q      <= 2'b00;
         addr_q    <= 19'h00000;
         wdata_q   <= 8'h00;
         cyc       <= 3'd0;
         idx       <= 3'd0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
         poll_cnt  <= 24'h000000;
         dq_q      <= 8'h00;
         prev_dq6  <= 1'b0;
         have_prev <= 1'b0;
         retry_q   <= 1'b0;
`ifdef RC755_FLASH_VERIFY_EN
         vfy_q     <= 1'b0;
`endif
      end else begin
         cyc <= (state_n != state) ? 3'd0 : cyc + 3'd1;
         if (accept) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            idx     <= 3'd0;
         end
         if (state == W_HOLD && state_n == W_SETUP)
            idx <= idx + 3'd1;
         if (poll_start) begin
            poll_cnt  <= 24'h000000;
            have_prev <= 1'b0;
            retry_q   <= 1'b0;
`ifdef RC755_FLASH_VERIFY_EN
            vfy_q     <= 1'b0;
`endif
         end
         if (rd_sample) begin
            dq_q <= FL_DI;
            if (poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + 24'd1;
         end
`ifdef RC755_FLASH_VERIFY_EN
         if (vfy_sample) begin
            dq_q  <= FL_DI;
            vfy_q <= 1'b1;
         end
`endif
         if (state == R_GAP) begin
            prev_dq6  <= dq_q[6];
            have_prev <= 1'b1;
            if (retry_set) retry_q <= 1'b1;
         end
         if (fail) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            idx     <= 3'd0;
         end
      end
   end

   // Strobes decode straight from state so reset parks the bus idle without waiting for a clock.
   always_comb begin
      FL_CEn = 1'b1;
      FL_WEn = 1'b1;
      FL_OEn = 1'b1;
      FL_DOE = 1'b0;
      FL_A   = 19'h00000;
      FL_DO  = 8'h00;
      case (state)
         W_SETUP, W_PULSE, W_HOLD: begin
            FL_A   = cmd_addr;
            FL_DO  = cmd_data;
            FL_DOE = 1'b1;
            FL_CEn = (state == W_HOLD);
            FL_WEn = (state != W_PULSE);
         end
         R_PULSE: begin
            FL_A   = addr_q;
            FL_CEn = 1'b0;
            FL_OEn = 1'b0;
         end
`ifdef RC755_FLASH_VERIFY_EN
         VERIFY: begin
            FL_A   = addr_q;
            FL_CEn = 1'b0;
            FL_OEn = 1'b0;
         end
`endif
         R_GAP:   FL_A = addr_q;
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == FINISH);
   assign err  = err_q;

endmodule

// File: tb/tb_rc755_flash_seq.sv
// tb_rc755_flash_seq: directed bench for rc755_flash_seq with a toggle-bit flash model.
// A second instance uses TO_POLLS=4 for the timeout scenario.
module tb_rc755_flash_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, req_t;
   logic [1:0]  op;
   logic [18:0] addr;
   logic [7:0]  wdata;

   logic        busy, done, err, fl_doe, fl_cen, fl_wen, fl_oen;
   logic [18:0] fl_a;
   logic [7:0]  fl_do, fl_di;
   logic        busy_t, done_t, err_t, fl_doe_t, fl_cen_t, fl_wen_t, fl_oen_t;
   logic [18:0] fl_a_t;
   logic [7:0]  fl_do_t, fl_di_t;

   int          compared = 0;
   int          failed   = 0;

   // Flash model state: mode 0 steady value, 1 toggle DQ6 for ten reads, 2 always toggle.
   logic [1:0]  mode, mode_t;
   logic [7:0]  steady, steady_t;
   logic        dq5, dq5_t;
   int          rd_cnt = 0, rd_cnt_t = 0;
   int          rd_base = 0, rd_base_t = 0;
   int          wl_base = 0, wl_base_t = 0;
   logic [18:0] wa[$], wa_t[$];
   logic [7:0]  wd[$], wd_t[$];

   always #5 clk = ~clk;

   rc755_flash_seq dut (
      .SLT_CLOCK(clk), .SLT_RESETn(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .FL_A(fl_a), .FL_DO(fl_do), .FL_DOE(fl_doe),
      .FL_DI(fl_di), .FL_CEn(fl_cen), .FL_WEn(fl_wen), .FL_OEn(fl_oen)
   );

   rc755_flash_seq #(.WE_CYC(2), .RD_CYC(2), .TO_POLLS(24'd4)) dut_t (
      .SLT_CLOCK(clk), .SLT_RESETn(rst_n), .req(req_t), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy_t), .done(done_t), .err(err_t), .FL_A(fl_a_t), .FL_DO(fl_do_t), .FL_DOE(fl_doe_t),
      .FL_DI(fl_di_t), .FL_CEn(fl_cen_t), .FL_WEn(fl_wen_t), .FL_OEn(fl_oen_t)
   );

   function automatic logic [7:0] flash_resp(input logic [1:0] m, input int c,
                                             input logic [7:0] sv, input logic d5);
      logic t;
      t = c[0];
      case (m)
         2'd1:    return {1'b0, (c < 10) ? t : 1'b1, 6'b0};
         2'd2:    return {1'b0, t, d5, 5'b0};
         default: return sv;
      endcase
   endfunction

   assign fl_di   = flash_resp(mode, rd_cnt - rd_base, steady, dq5);
   assign fl_di_t = flash_resp(mode_t, rd_cnt_t - rd_base_t, steady_t, dq5_t);

   // Reads are counted as OEn releases; writes are logged on the WEn rising edge.
   always @(posedge fl_oen)   if (rst_n) rd_cnt++;
   always @(posedge fl_oen_t) if (rst_n) rd_cnt_t++;
   always @(posedge fl_wen)   if (rst_n) begin wa.push_back(fl_a);   wd.push_back(fl_do);   end
   always @(posedge fl_wen_t) if (rst_n) begin wa_t.push_back(fl_a_t); wd_t.push_back(fl_do_t); end

   task automatic start_op(input bit sel, input logic [1:0] o, input logic [18:0] a,
                           input logic [7:0] d, input bit hold);
      op = o; addr = a; wdata = d;
      if (sel) begin
         rd_base_t = rd_cnt_t; wl_base_t = wa_t.size(); req_t = 1'b1;
      end else begin
         rd_base = rd_cnt; wl_base = wa.size(); req = 1'b1;
      end
      @(negedge clk);
      if (!hold) begin req = 1'b0; req_t = 1'b0; end
   endtask

   task automatic run_until_done(input bit sel, inout int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ((sel ? done_t : done) === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      compared++; if ({busy, done, err} !== 3'b000) begin failed++; $display("[TB] FAIL rst_flags: got %b want 000", {busy, done, err}); end
      compared++; if ({fl_cen, fl_wen, fl_oen, fl_doe} !== 4'b1110) begin failed++; $display("[TB] FAIL rst_strobes: got %b want 1110", {fl_cen, fl_wen, fl_oen, fl_doe}); end
      compared++; if ({fl_a, fl_do} !== 27'h0) begin failed++; $display("[TB] FAIL rst_bus: got %h/%h want 0/0", fl_a, fl_do); end
      rst_n = 1'b1;
      @(negedge clk);
      compared++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_program;
      logic [18:0] ea[4];
      logic [7:0]  ed[4];
      int k; bit ok;
      ea = '{19'h00555, 19'h002AA, 19'h00555, 19'h0A123};
      ed = '{8'hAA, 8'h55, 8'hA0, 8'h5A};
      mode = 2'd0; steady = 8'h40;
      start_op(1'b0, 2'b00, 19'h0A123, 8'h5A, 1'b0);
      k = 0;
      compared++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL prog_busy: got %b want 1", busy); end
      compared++; if ({fl_cen, fl_wen, fl_oen, fl_doe} !== 4'b0111) begin failed++; $display("[TB] FAIL prog_setup_strobes: got %b want 0111", {fl_cen, fl_wen, fl_oen, fl_doe}); end
      compared++; if ({fl_a, fl_do} !== {19'h00555, 8'hAA}) begin failed++; $display("[TB] FAIL prog_setup_bus: got %h/%h want 555/AA", fl_a, fl_do); end
      @(negedge clk); k++;
      compared++; if ({fl_cen, fl_wen} !== 2'b00) begin failed++; $display("[TB] FAIL prog_pulse: got %b want 00", {fl_cen, fl_wen}); end
      repeat (14) begin @(negedge clk); k++; end
      compared++; if ({fl_cen, fl_wen, fl_oen, fl_a, fl_do} !== {3'b111, 19'h0A123, 8'h5A}) begin failed++; $display("[TB] FAIL prog_hold: got %b %h/%h want 111 0A123/5A", {fl_cen, fl_wen, fl_oen}, fl_a, fl_do); end
      @(negedge clk); k++;
      compared++; if ({fl_cen, fl_wen, fl_oen, fl_doe, fl_a} !== {4'b0100, 19'h0A123}) begin failed++; $display("[TB] FAIL prog_first_read: got %b %h want 0100 0A123", {fl_cen, fl_wen, fl_oen, fl_doe}, fl_a); end
      run_until_done(1'b0, k, ok);
      compared++; if (!ok || k != 22) begin failed++; $display("[TB] FAIL prog_done_cycle: got ok=%0d k=%0d want ok=1 k=22", ok, k); end
      compared++; if (err !== 1'b0) begin failed++; $display("[TB] FAIL prog_err: got %b want 0", err); end
      compared++; if (rd_cnt - rd_base != 2) begin failed++; $display("[TB] FAIL prog_reads: got %0d want 2", rd_cnt - rd_base); end
      compared++; if (wa.size() - wl_base != 4) begin failed++; $display("[TB] FAIL prog_nwrites: got %0d want 4", wa.size() - wl_base); end
      if (wa.size() >= wl_base + 4)
         for (int i = 0; i < 4; i++) begin
            compared++; if ({wa[wl_base+i], wd[wl_base+i]} !== {ea[i], ed[i]}) begin failed++; $display("[TB] FAIL prog_write%0d: got %h/%h want %h/%h", i, wa[wl_base+i], wd[wl_base+i], ea[i], ed[i]); end
         end
      @(negedge clk);
      compared++; if ({busy, done} !== 2'b00) begin failed++; $display("[TB] FAIL prog_after_done: got %b want 00", {busy, done}); end
   endtask

   task automatic test_sector_erase;
      logic [18:0] ea[6];
      logic [7:0]  ed[6];
      int k; bit ok;
      ea = '{19'h00555, 19'h002AA, 19'h00555, 19'h00555, 19'h002AA, 19'h40000};
      ed = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
      mode = 2'd1;
      start_op(1'b0, 2'b01, 19'h40000, 8'h00, 1'b0);
      k = 0;
      run_until_done(1'b0, k, ok);
      compared++; if (!ok || k != 57) begin failed++; $display("[TB] FAIL sect_done_cycle: got ok=%0d k=%0d want ok=1 k=57", ok, k); end
      compared++; if (err !== 1'b0) begin failed++; $display("[TB] FAIL sect_err: got %b want 0", err); end
      compared++; if (rd_cnt - rd_base != 11) begin failed++; $display("[TB] FAIL sect_reads: got %0d want 11", rd_cnt - rd_base); end
      compared++; if (wa.size() - wl_base != 6) begin failed++; $display("[TB] FAIL sect_nwrites: got %0d want 6", wa.size() - wl_base); end
      if (wa.size() >= wl_base + 6)
         for (int i = 0; i < 6; i++) begin
            compared++; if ({wa[wl_base+i], wd[wl_base+i]} !== {ea[i], ed[i]}) begin failed++; $display("[TB] FAIL sect_write%0d: got %h/%h want %h/%h", i, wa[wl_base+i], wd[wl_base+i], ea[i], ed[i]); end
         end
      @(negedge clk);
   endtask

   task automatic test_chip_erase_dq5;
      int k; bit ok;
      mode = 2'd2; dq5 = 1'b1;
      start_op(1'b0, 2'b10, 19'h00000, 8'h00, 1'b0);
      k = 0;
      run_until_done(1'b0, k, ok);
      compared++; if (!ok || k != 37) begin failed++; $display("[TB] FAIL chip_done_cycle: got ok=%0d k=%0d want ok=1 k=37", ok, k); end
      compared++; if (err !== 1'b1) begin failed++; $display("[TB] FAIL chip_err: got %b want 1", err); end
      compared++; if (rd_cnt - rd_base != 3) begin failed++; $display("[TB] FAIL chip_reads: got %0d want 3", rd_cnt - rd_base); end
      compared++; if (wa.size() - wl_base != 7) begin failed++; $display("[TB] FAIL chip_nwrites: got %0d want 7", wa.size() - wl_base); end
      if (wa.size() >= wl_base + 7) begin
         compared++; if ({wa[wl_base+5], wd[wl_base+5]} !== {19'h00555, 8'h10}) begin failed++; $display("[TB] FAIL chip_cmd: got %h/%h want 555/10", wa[wl_base+5], wd[wl_base+5]); end
         compared++; if ({wa[wl_base+6], wd[wl_base+6]} !== {19'h00000, 8'hF0}) begin failed++; $display("[TB] FAIL chip_f0: got %h/%h want 0/F0", wa[wl_base+6], wd[wl_base+6]); end
      end
      repeat (3) @(negedge clk);
      compared++; if ({busy, err} !== 2'b01) begin failed++; $display("[TB] FAIL chip_err_hold: got %b want 01", {busy, err}); end
   endtask

   task automatic test_err_clear;
      int k; bit ok;
      start_op(1'b0, 2'b11, 19'h12345, 8'h00, 1'b0);
      k = 0;
      compared++; if ({busy, err} !== 2'b10) begin failed++; $display("[TB] FAIL clr_err: got %b want 10", {busy, err}); end
      compared++; if ({fl_a, fl_do} !== {19'h00000, 8'hF0}) begin failed++; $display("[TB] FAIL clr_bus: got %h/%h want 0/F0", fl_a, fl_do); end
      run_until_done(1'b0, k, ok);
      compared++; if (!ok || k != 4) begin failed++; $display("[TB] FAIL clr_done_cycle: got ok=%0d k=%0d want ok=1 k=4", ok, k); end
      compared++; if (rd_cnt - rd_base != 0 || wa.size() - wl_base != 1) begin failed++; $display("[TB] FAIL clr_counts: got reads=%0d writes=%0d want 0/1", rd_cnt - rd_base, wa.size() - wl_base); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int k; bit ok; bit seen;
      mode_t = 2'd2; dq5_t = 1'b0;
      start_op(1'b1, 2'b01, 19'h12345, 8'h00, 1'b1);
      k = 0;
      run_until_done(1'b1, k, ok);
      req_t = 1'b0;
      compared++; if (!ok || k != 40) begin failed++; $display("[TB] FAIL to_done_cycle: got ok=%0d k=%0d want ok=1 k=40", ok, k); end
      compared++; if (err_t !== 1'b1) begin failed++; $display("[TB] FAIL to_err: got %b want 1", err_t); end
      compared++; if (rd_cnt_t - rd_base_t != 4) begin failed++; $display("[TB] FAIL to_reads: got %0d want 4", rd_cnt_t - rd_base_t); end
      compared++; if (wa_t.size() - wl_base_t != 7) begin failed++; $display("[TB] FAIL to_nwrites: got %0d want 7", wa_t.size() - wl_base_t); end
      if (wa_t.size() >= wl_base_t + 7) begin
         compared++; if ({wa_t[wl_base_t+6], wd_t[wl_base_t+6]} !== {19'h00000, 8'hF0}) begin failed++; $display("[TB] FAIL to_f0: got %h/%h want 0/F0", wa_t[wl_base_t+6], wd_t[wl_base_t+6]); end
      end
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (busy_t) seen = 1'b1; end
      compared++; if (seen || wa_t.size() - wl_base_t != 7) begin failed++; $display("[TB] FAIL to_no_restart: got busy_seen=%0d writes=%0d want 0/7", seen, wa_t.size() - wl_base_t); end
   endtask

   task automatic test_verify;
      int k; bit ok;
      logic exp_err;
      int   exp_nw;
`ifdef RC755_FLASH_VERIFY_EN
      exp_err = 1'b1; exp_nw = 5;
`else
      exp_err = 1'b0; exp_nw = 4;
`endif
      mode = 2'd0; steady = 8'hA4;
      start_op(1'b0, 2'b00, 19'h00777, 8'hA5, 1'b0);
      k = 0;
      run_until_done(1'b0, k, ok);
      compared++; if (!ok) begin failed++; $display("[TB] FAIL vfy_done: got ok=0 want ok=1"); end
      compared++; if (err !== exp_err) begin failed++; $display("[TB] FAIL vfy_err: got %b want %b", err, exp_err); end
      compared++; if (wa.size() - wl_base != exp_nw) begin failed++; $display("[TB] FAIL vfy_nwrites: got %0d want %0d", wa.size() - wl_base, exp_nw); end
      if (wa.size() >= wl_base + 4) begin
         compared++; if ({wa[wl_base+3], wd[wl_base+3]} !== {19'h00777, 8'hA5}) begin failed++; $display("[TB] FAIL vfy_data_write: got %h/%h want 00777/A5", wa[wl_base+3], wd[wl_base+3]); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit seen;
      mode = 2'd0; steady = 8'h40;
      start_op(1'b0, 2'b00, 19'h0A123, 8'h5A, 1'b0);
      @(negedge clk);
      compared++; if (fl_wen !== 1'b0) begin failed++; $display("[TB] FAIL mid_pulse_wen: got %b want 0", fl_wen); end
      #2 rst_n = 1'b0;
      #1;
      compared++; if ({fl_wen, fl_cen, busy, done} !== 4'b1100) begin failed++; $display("[TB] FAIL mid_reset: got %b want 1100", {fl_wen, fl_cen, busy, done}); end
      compared++; if ({fl_doe, fl_a, fl_do} !== 28'h0) begin failed++; $display("[TB] FAIL mid_reset_bus: got %b %h/%h want 0 0/0", fl_doe, fl_a, fl_do); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin @(negedge clk); if (busy || done) seen = 1'b1; end
      compared++; if (seen) begin failed++; $display("[TB] FAIL mid_no_resume: got activity=1 want 0"); end
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; req_t = 1'b0;
      op = 2'b00; addr = 19'h0; wdata = 8'h0;
      mode = 2'd0; mode_t = 2'd0; steady = 8'h00; steady_t = 8'h00; dq5 = 1'b0; dq5_t = 1'b0;
      test_reset;
      test_program;
      test_sector_erase;
      test_chip_erase_dq5;
      test_err_clear;
      test_timeout;
      test_verify;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
